// File: rtl/boot_pkg.sv
// Shared types for the boot controller: FSM states and halt-cause codes.
// Imported by boot_ctrl and boot_wdog.
package boot_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_CLEAR,
      ST_RUN,
      ST_HALT
   } boot_state_e;

   typedef logic [1:0] halt_cause_t;

   localparam halt_cause_t HC_NONE = 2'b00;
   localparam halt_cause_t HC_REQ  = 2'b01;
   localparam halt_cause_t HC_WDOG = 2'b10;

   function automatic int max_aw(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/boot_wdog.sv
// Saturating RUN-cycle counter with a limit compare.
// Instantiated only when BOOT_CTRL_WDOG_EN is defined.
module boot_wdog
   import boot_pkg::*;
#(
   parameter int unsigned LIMIT = 100
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        en,
   output logic [31:0] cnt,
   output logic        hit
);

   localparam logic [31:0] LIMIT_M1 = 32'(LIMIT - 1);

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 32'd1;
      end
   end

   // Flag the cycle whose increment lands the count on LIMIT.
   assign hit = en && (cnt == LIMIT_M1);

endmodule

// File: rtl/boot_ctrl.sv
// Boot sequencer: program load, memory/RF clear, core run and halt.
// Define BOOT_CTRL_WDOG_EN to add the RUN-cycle watchdog.
module boot_ctrl
   import boot_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int IMEM_AW     = 8,
   parameter int DMEM_AW     = 6,
   parameter int RF_AW       = 5,
   parameter int WDOG_CYCLES = 100
) (
   input  logic               clk,
   input  logic               areset,
   input  logic               ld_valid,
   input  logic [XLEN-1:0]    ld_data,
   input  logic               ld_last,
   output logic               ld_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [XLEN-1:0]    imem_wdata,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic               rf_we,
   output logic [RF_AW-1:0]   rf_addr,
   output logic               core_rst_n,
   output logic               core_clk_en,
   input  logic               halt_req,
   output logic               halted,
   output logic [1:0]         halt_cause,
   output logic [31:0]        cycle_cnt,
   output logic [IMEM_AW:0]   prog_len
);

   localparam int CW = max_aw(DMEM_AW, RF_AW);
   localparam logic [CW-1:0] CLR_LAST = '1;
   localparam logic [CW:0]   DMEM_N   = (CW+1)'(2 ** DMEM_AW);
   localparam logic [CW:0]   RF_N     = (CW+1)'(2 ** RF_AW);
   localparam logic [IMEM_AW:0] LEN_ONE = (IMEM_AW+1)'(1);
   localparam logic [CW-1:0] CLR_ONE  = CW'(1);

   if (WDOG_CYCLES < 1) begin : g_bad_wdog
      $error("WDOG_CYCLES must be at least 1");
   end

   boot_state_e        state;
   boot_state_e        state_nx;
   logic               live;
   logic               ld_fire;
   logic               run;
   logic               wdog_hit;
   logic [IMEM_AW-1:0] ptr;
   logic [CW-1:0]      clr_cnt;

   assign ptr     = prog_len[IMEM_AW-1:0];
   assign ld_fire = ld_valid && ld_ready;
   assign run     = (state == ST_RUN);

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      ld_ready    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = '0;
      rf_we       = 1'b0;
      rf_addr     = '0;
      core_rst_n  = 1'b0;
      core_clk_en = 1'b0;
      halted      = 1'b0;
      unique case (state)
         ST_LOAD: begin
            // live keeps ready low until the first clock after reset
            ld_ready = live;
            if (ld_valid && live && (ld_last || (&ptr))) begin
               state_nx = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            dmem_we   = ({1'b0, clr_cnt} < DMEM_N);
            rf_we     = ({1'b0, clr_cnt} < RF_N);
            dmem_addr = clr_cnt[DMEM_AW-1:0];
            rf_addr   = clr_cnt[RF_AW-1:0];
            if (clr_cnt == CLR_LAST) begin
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            core_rst_n  = 1'b1;
            core_clk_en = 1'b1;
            if (halt_req || wdog_hit) begin
               state_nx = ST_HALT;
            end
         end
         ST_HALT: begin
            core_rst_n = 1'b1;
            halted     = 1'b1;
         end
         default: state_nx = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         live       <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         prog_len   <= '0;
         clr_cnt    <= '0;
         halt_cause <= HC_NONE;
      end else begin
         live    <= 1'b1;
         imem_we <= ld_fire;
         if (ld_fire) begin
            imem_addr  <= ptr;
            imem_wdata <= ld_data;
            prog_len   <= prog_len + LEN_ONE;
         end
         if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + CLR_ONE;
         end
         // halt_req takes priority over a coincident watchdog hit
         if (run && (state_nx == ST_HALT)) begin
            halt_cause <= halt_req ? HC_REQ : HC_WDOG;
         end
      end
   end

`ifdef BOOT_CTRL_WDOG_EN
   boot_wdog #(
      .LIMIT(WDOG_CYCLES)
   ) u_wdog (
      .clk   (clk),
      .areset(areset),
      .en    (run),
      .cnt   (cycle_cnt),
      .hit   (wdog_hit)
   );
`else
   assign wdog_hit = 1'b0;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         cycle_cnt <= '0;
      end else if (run && (cycle_cnt != '1)) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: load, full stream, clear, halt, watchdog.
// Watchdog checks follow BOOT_CTRL_WDOG_EN.
module tb_boot_ctrl;

   logic        clk = 1'b0;
   logic        areset;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        dmem_we;
   logic [5:0]  dmem_addr;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic        core_rst_n;
   logic        core_clk_en;
   logic        halt_req;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [31:0] cycle_cnt;
   logic [8:0]  prog_len;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   boot_ctrl #(
      .XLEN(32), .IMEM_AW(8), .DMEM_AW(6), .RF_AW(5), .WDOG_CYCLES(100)
   ) dut (
      .clk(clk), .areset(areset),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .rf_we(rf_we), .rf_addr(rf_addr),
      .core_rst_n(core_rst_n), .core_clk_en(core_clk_en),
      .halt_req(halt_req), .halted(halted), .halt_cause(halt_cause),
      .cycle_cnt(cycle_cnt), .prog_len(prog_len)
   );

   task automatic do_reset;
      areset = 1'b0;
      ld_valid = 1'b0;
      ld_last = 1'b0;
      ld_data = '0;
      halt_req = 1'b0;
      repeat (2) @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
   endtask

   task automatic boot_to_run;
      do_reset;
      ld_valid = 1'b1;
      ld_data = 32'h13;
      ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last = 1'b0;
      repeat (64) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [6:0] flags;
      logic [42:0] stat;
      @(negedge clk);
      areset = 1'b0;
      #1;
      flags = {ld_ready, imem_we, dmem_we, rf_we,
               core_rst_n, core_clk_en, halted};
      n_tests++;
      if (flags !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0", flags);
      end
      stat = {cycle_cnt, prog_len, halt_cause};
      n_tests++;
      if (stat !== 43'b0) begin
         n_fail++;
         $display("FAIL reset_status: got %0h expected 0", stat);
      end
      @(negedge clk);
      areset = 1'b1;
      #1;
      n_tests++;
      if (ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_clk: got %b expected 0", ld_ready);
      end
      @(negedge clk);
      n_tests++;
      if ({ld_ready, core_rst_n} !== 2'b10) begin
         n_fail++;
         $display("FAIL ready_after_clk: got %b expected 10",
                  {ld_ready, core_rst_n});
      end
   endtask

   task automatic test_load5;
      logic [40:0] got;
      logic [40:0] exp;
      do_reset;
      n_tests++;
      if (imem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL load5_idle_we: got %b expected 0", imem_we);
      end
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1'b1;
         ld_data = 32'h13 + 32'(i);
         ld_last = (i == 4);
         @(negedge clk);
         got = {imem_we, imem_addr, imem_wdata};
         exp = {1'b1, 8'(i), 32'h13 + 32'(i)};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL load5_write%0d: got %0h expected %0h",
                     i, got, exp);
         end
      end
      ld_valid = 1'b0;
      ld_last = 1'b0;
      n_tests++;
      if (prog_len !== 9'd5) begin
         n_fail++;
         $display("FAIL load5_len: got %0d expected 5", prog_len);
      end
      n_tests++;
      if ({ld_ready, dmem_we, dmem_addr} !== {1'b0, 1'b1, 6'd0}) begin
         n_fail++;
         $display("FAIL load5_clear: got %b expected 0_1_000000",
                  {ld_ready, dmem_we, dmem_addr});
      end
      @(negedge clk);
      n_tests++;
      if (imem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL load5_no_extra: got %b expected 0", imem_we);
      end
   endtask

   task automatic test_full;
      int acc;
      int wr;
      int drop;
      logic [7:0] last_addr;
      acc = 0;
      wr = 0;
      drop = -1;
      last_addr = '0;
      do_reset;
      for (int c = 0; c < 300; c++) begin
         if (ld_ready === 1'b1) acc++;
         else if (drop < 0) drop = c;
         ld_valid = 1'b1;
         ld_data = 32'(c);
         @(negedge clk);
         if (imem_we === 1'b1) begin
            wr++;
            last_addr = imem_addr;
         end
      end
      ld_valid = 1'b0;
      n_tests++;
      if (acc != 256) begin
         n_fail++;
         $display("FAIL full_accepted: got %0d expected 256", acc);
      end
      n_tests++;
      if (wr != 256) begin
         n_fail++;
         $display("FAIL full_writes: got %0d expected 256", wr);
      end
      n_tests++;
      if (drop != 256) begin
         n_fail++;
         $display("FAIL full_ready_drop: got %0d expected 256", drop);
      end
      n_tests++;
      if (last_addr !== 8'd255) begin
         n_fail++;
         $display("FAIL full_last_addr: got %0d expected 255", last_addr);
      end
      n_tests++;
      if (prog_len !== 9'd256) begin
         n_fail++;
         $display("FAIL full_len: got %0d expected 256", prog_len);
      end
   endtask

   task automatic test_clear;
      logic [14:0] got;
      logic [14:0] exp;
      do_reset;
      halt_req = 1'b1;
      ld_valid = 1'b1;
      ld_data = 32'hdead_beef;
      ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last = 1'b0;
      for (int j = 0; j < 64; j++) begin
         got = {dmem_we, dmem_addr, rf_we, rf_addr, core_rst_n, core_clk_en};
         exp = {1'b1, 6'(j), (j < 32) ? 1'b1 : 1'b0, 5'(j), 2'b00};
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL clear_step%0d: got %b expected %b", j, got, exp);
         end
         if (j == 63) halt_req = 1'b0;
         @(negedge clk);
      end
      got = {dmem_we, 6'd0, rf_we, 5'd0, core_rst_n, core_clk_en};
      n_tests++;
      if (got !== 15'b11) begin
         n_fail++;
         $display("FAIL clear_to_run: got %b expected 11", got);
      end
      n_tests++;
      if ({halted, cycle_cnt} !== 33'd0) begin
         n_fail++;
         $display("FAIL clear_halt_ignored: got %0h expected 0",
                  {halted, cycle_cnt});
      end
   endtask

   task automatic test_halt_req;
      boot_to_run;
      repeat (39) @(negedge clk);
      n_tests++;
      if (cycle_cnt !== 32'd39) begin
         n_fail++;
         $display("FAIL halt_pre_cnt: got %0d expected 39", cycle_cnt);
      end
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      n_tests++;
      if ({halted, halt_cause, cycle_cnt, core_clk_en, core_rst_n} !==
          {1'b1, 2'b01, 32'd40, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL halt_req: got h%b c%b n%0d en%b rst%b expected 1 01 40 0 1",
                  halted, halt_cause, cycle_cnt, core_clk_en, core_rst_n);
      end
      repeat (10) @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      n_tests++;
      if ({halted, halt_cause, cycle_cnt} !== {1'b1, 2'b01, 32'd40}) begin
         n_fail++;
         $display("FAIL halt_frozen: got h%b c%b n%0d expected 1 01 40",
                  halted, halt_cause, cycle_cnt);
      end
   endtask

   task automatic test_watchdog;
`ifdef BOOT_CTRL_WDOG_EN
      int k;
      boot_to_run;
      k = 0;
      while (halted !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (k != 100) begin
         n_fail++;
         $display("FAIL wdog_cycles: got %0d expected 100", k);
      end
      n_tests++;
      if ({halted, halt_cause, cycle_cnt} !== {1'b1, 2'b10, 32'd100}) begin
         n_fail++;
         $display("FAIL wdog_halt: got h%b c%b n%0d expected 1 10 100",
                  halted, halt_cause, cycle_cnt);
      end
      boot_to_run;
      repeat (99) @(negedge clk);
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      n_tests++;
      if ({halted, halt_cause, cycle_cnt} !== {1'b1, 2'b01, 32'd100}) begin
         n_fail++;
         $display("FAIL wdog_tie: got h%b c%b n%0d expected 1 01 100",
                  halted, halt_cause, cycle_cnt);
      end
`else
      boot_to_run;
      repeat (120) @(negedge clk);
      n_tests++;
      if ({halted, halt_cause, cycle_cnt} !== {1'b0, 2'b00, 32'd120}) begin
         n_fail++;
         $display("FAIL no_wdog_run: got h%b c%b n%0d expected 0 00 120",
                  halted, halt_cause, cycle_cnt);
      end
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      n_tests++;
      if ({halted, halt_cause, cycle_cnt} !== {1'b1, 2'b01, 32'd121}) begin
         n_fail++;
         $display("FAIL no_wdog_halt: got h%b c%b n%0d expected 1 01 121",
                  halted, halt_cause, cycle_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid_clear;
      logic [100:0] outs;
      do_reset;
      ld_valid = 1'b1;
      ld_data = 32'h1234_5678;
      ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last = 1'b0;
      repeat (20) @(negedge clk);
      n_tests++;
      if ({dmem_we, dmem_addr} !== {1'b1, 6'd20}) begin
         n_fail++;
         $display("FAIL midclr_count: got %b expected 1_010100",
                  {dmem_we, dmem_addr});
      end
      areset = 1'b0;
      #1;
      outs = {ld_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
              rf_we, rf_addr, core_rst_n, core_clk_en, halted, halt_cause,
              cycle_cnt, prog_len};
      n_tests++;
      if (outs !== 101'b0) begin
         n_fail++;
         $display("FAIL midclr_outs: got %0h expected 0", outs);
      end
      @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({ld_ready, prog_len, dmem_we} !== {1'b1, 9'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL midclr_reload: got rdy%b len%0d dwe%b expected 1 0 0",
                  ld_ready, prog_len, dmem_we);
      end
   endtask

   initial begin
      areset = 1'b0;
      ld_valid = 1'b0;
      ld_last = 1'b0;
      ld_data = '0;
      halt_req = 1'b0;
      test_reset;
      test_load5;
      test_full;
      test_clear;
      test_halt_req;
      test_watchdog;
      test_reset_mid_clear;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
